fifo_128_pix_unpack: RTL and testbench

FIFO_128_PIX_UNPACK -- requirements
Module: fifo_128_pix_unpack

---
 rtl/fifo_128_pix_unpack_pkg.sv | 23 ++
 rtl/fifo_128_pix_unpack_pix_line_cnt.sv | 37 +++
 rtl/fifo_128_pix_unpack.sv | 101 ++++++++++
 tb/tb_fifo_128_pix_unpack.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_128_pix_unpack_pkg.sv
// rtl/fifo_128_pix_unpack_pkg.sv - shared widths and lane select helper for the 128-bit pixel unpacker
package fifo_128_pix_unpack_pkg;

  localparam int PIX_W  = 32;
  localparam int WORD_W = 128;
  localparam int LANES  = 4;
  localparam int CNT_W  = 12;

  typedef logic [1:0] lane_t;

  function automatic logic [PIX_W-1:0] lane_pick(input logic [WORD_W-1:0] word,
                                                 input lane_t             lane);
    logic [PIX_W-1:0] pix;
    case (lane)
      2'd0:    pix = word[31:0];
      2'd1:    pix = word[63:32];
      2'd2:    pix = word[95:64];
      default: pix = word[127:96];
    endcase
    return pix;
  endfunction

endpackage

// File: rtl/fifo_128_pix_unpack_pix_line_cnt.sv
// rtl/fifo_128_pix_unpack_pix_line_cnt.sv - per-line pixel transfer counter and end-of-line flag
module pix_line_cnt
  import fifo_128_pix_unpack_pkg::*;
#(
  parameter int LINE_PIX = 1920
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             xfer_i,
  output logic [CNT_W-1:0] count_o,
  output logic             eol_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_PIX - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (xfer_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign eol_o   = (count_q == LAST);

endmodule

// File: rtl/fifo_128_pix_unpack.sv
// rtl/fifo_128_pix_unpack.sv - unpacks 128-bit FIFO words into a 32-bit pixel stream, lane 0 first
module fifo_128_pix_unpack
  import fifo_128_pix_unpack_pkg::*;
#(
  parameter int LINE_PIX = 1920
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_eol,
  output logic              underrun
);

  logic [WORD_W-1:0] cur_q, cur_d;
  logic [WORD_W-1:0] nxt_q, nxt_d;
  logic              cur_vld_q, cur_vld_d;
  logic              nxt_vld_q, nxt_vld_d;
  logic              rd_pend_q;
  logic              underrun_q, underrun_d;
  lane_t             lane_q, lane_d;

  logic              xfer;
  logic              load_cur;
  logic [CNT_W-1:0]  count;

  // A read is only issued into an empty nxt slot, so a pending capture never overwrites valid data.
  assign fifo_rd_en = !fifo_empty && !rd_pend_q && !nxt_vld_q && !rst;

  assign pix_valid = cur_vld_q;
  assign pix_data  = lane_pick(cur_q, lane_q);
  assign underrun  = underrun_q;

  assign xfer     = cur_vld_q && pix_ready;
  assign load_cur = (xfer && (lane_q == 2'd3)) || (!cur_vld_q && nxt_vld_q);

  always_comb begin
    cur_d      = cur_q;
    cur_vld_d  = cur_vld_q;
    lane_d     = lane_q;
    nxt_d      = nxt_q;
    nxt_vld_d  = nxt_vld_q;
    underrun_d = underrun_q;

    if (load_cur) begin
      cur_d     = nxt_q;
      cur_vld_d = nxt_vld_q;
      lane_d    = 2'd0;
    end else if (xfer) begin
      lane_d = lane_q + 2'd1;
    end

    // The returning read lands in nxt even when nxt is handed to cur in the same edge.
    if (rd_pend_q) begin
      nxt_d     = fifo_dout;
      nxt_vld_d = 1'b1;
    end else if (load_cur) begin
      nxt_vld_d = 1'b0;
    end

    if (!cur_vld_q && (count != '0) && pix_ready) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_vld_q  <= 1'b0;
      nxt_vld_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      lane_q     <= 2'd0;
      underrun_q <= 1'b0;
    end else begin
      cur_vld_q  <= cur_vld_d;
      nxt_vld_q  <= nxt_vld_d;
      rd_pend_q  <= fifo_rd_en;
      lane_q     <= lane_d;
      underrun_q <= underrun_d;
    end
  end

  always_ff @(posedge clk) begin
    cur_q <= cur_d;
    nxt_q <= nxt_d;
  end

  pix_line_cnt #(
    .LINE_PIX(LINE_PIX)
  ) u_line_cnt (
    .clk    (clk),
    .rst    (rst),
    .xfer_i (xfer),
    .count_o(count),
    .eol_o  (pix_eol)
  );

endmodule

// File: tb/tb_fifo_128_pix_unpack.sv
// tb/tb_fifo_128_pix_unpack.sv - scoreboard bench for the 128-bit pixel unpacker with an 8-pixel line
module tb_fifo_128_pix_unpack;

  localparam int LINE = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] fifo_dout = '0;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [31:0]  pix_data;
  logic         pix_valid;
  logic         pix_ready = 1'b0;
  logic         pix_eol;
  logic         underrun;

  fifo_128_pix_unpack #(
    .LINE_PIX(LINE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_eol   (pix_eol),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Upstream FIFO model: data appears on fifo_dout the cycle after fifo_rd_en.
  logic [127:0] fifo_q[$];
  int           fifo_cnt = 0;
  assign fifo_empty = (fifo_cnt == 0);

  always @(posedge clk) begin
    if (fifo_rd_en && fifo_cnt > 0) begin
      fifo_dout <= fifo_q.pop_front();
      fifo_cnt  = fifo_cnt - 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic [31:0] exp_q[$];
  int          line_cnt, rd_cnt, xfer_cnt, eol_cnt, bubble_cnt, ahead_max;
  int          first_rd_cyc, first_cyc, last_cyc;
  logic [31:0] first_pix;
  logic        stall_q;
  logic [31:0] stall_data;
  logic        stall_eol;

  task automatic clear_stats();
    line_cnt = 0; rd_cnt = 0; xfer_cnt = 0; eol_cnt = 0; bubble_cnt = 0; ahead_max = 0;
    first_rd_cyc = 0; first_cyc = 0; last_cyc = 0; first_pix = '0; stall_q = 1'b0;
  endtask

  task automatic push_word(input logic [127:0] w);
    fifo_q.push_back(w);
    fifo_cnt = fifo_cnt + 1;
    for (int i = 0; i < 4; i++) exp_q.push_back(w[32*i +: 32]);
  endtask

  task automatic rebuild_exp();
    exp_q.delete();
    foreach (fifo_q[k]) begin
      logic [127:0] w;
      w = fifo_q[k];
      for (int i = 0; i < 4; i++) exp_q.push_back(w[32*i +: 32]);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    rebuild_exp();
    clear_stats();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (exp_q.size() != 0) check_val({tag, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      int ahead;
      if (fifo_rd_en) begin
        if (rd_cnt == 0) first_rd_cyc = cyc;
        rd_cnt++;
      end
      if (stall_q) begin
        check_val("stall_valid", 32'(pix_valid), 32'd1);
        check_val("stall_data", pix_data, stall_data);
        check_val("stall_eol", 32'(pix_eol), 32'(stall_eol));
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          check_val("extra_pixel", pix_data, 32'hdead_beef);
        end else begin
          check_val("pix_data", pix_data, exp_q.pop_front());
        end
        check_val("pix_eol", 32'(pix_eol), 32'(line_cnt == LINE - 1));
        line_cnt = (line_cnt == LINE - 1) ? 0 : line_cnt + 1;
        if (pix_eol) eol_cnt++;
        if (xfer_cnt == 0) begin
          first_cyc = cyc;
          first_pix = pix_data;
        end
        last_cyc = cyc;
        xfer_cnt++;
      end else if (pix_ready && !pix_valid && xfer_cnt > 0 && exp_q.size() > 0) begin
        bubble_cnt++;
      end
      stall_q    = pix_valid && !pix_ready;
      stall_data = pix_data;
      stall_eol  = pix_eol;
      ahead      = rd_cnt - xfer_cnt / 4;
      if (ahead > ahead_max) ahead_max = ahead;
    end else begin
      stall_q = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] w;
    logic [127:0] w4;
    int           k;
    clear_stats();

    // Reset state.
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check_val("rst_pix_valid", 32'(pix_valid), 32'd0);
    check_val("rst_pix_eol", 32'(pix_eol), 32'd0);
    check_val("rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
    check_val("rst_underrun", 32'(underrun), 32'd0);
    rst = 1'b0;

    // Single word: one read, 4 pixels, first pixel 3 cycles after the read.
    clear_stats();
    pix_ready = 1'b1;
    push_word(128'h00000004_00000003_00000002_00000001);
    wait_drain("t1", 50);
    check_val("t1_rd_pulses", 32'(rd_cnt), 32'd1);
    check_val("t1_latency", 32'(first_cyc - first_rd_cyc), 32'd3);
    check_val("t1_span", 32'(last_cyc - first_cyc), 32'd3);

    // 16 words back-to-back.
    pix_ready = 1'b0;
    do_reset(2);
    pix_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w = {$urandom(), $urandom(), $urandom(), $urandom()};
      push_word(w);
    end
    wait_drain("t2", 200);
    check_val("t2_rd_pulses", 32'(rd_cnt), 32'd16);
    check_val("t2_xfers", 32'(xfer_cnt), 32'd64);
    check_val("t2_bubbles", 32'(bubble_cnt), 32'd0);
    check_val("t2_span", 32'(last_cyc - first_cyc), 32'd63);
    check_val("t2_eols", 32'(eol_cnt), 32'd8);
    repeat (3) begin @(posedge clk); #1; end
    check_val("t2_no_underrun", 32'(underrun), 32'd0);

    // Line of 8: eol on transfers 8 and 16, counter wraps so no underrun after.
    pix_ready = 1'b0;
    do_reset(2);
    pix_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word({32'h3000 + 32'(4*i+3), 32'h3000 + 32'(4*i+2),
                                            32'h3000 + 32'(4*i+1), 32'h3000 + 32'(4*i)});
    wait_drain("t3", 100);
    check_val("t3_eols", 32'(eol_cnt), 32'd2);
    repeat (3) begin @(posedge clk); #1; end
    check_val("t3_wrap_no_underrun", 32'(underrun), 32'd0);
    check_val("t3_eol_idle", 32'(pix_eol), 32'd0);

    // Ready toggling: data holds while stalled, never more than 2 words ahead.
    pix_ready = 1'b0;
    do_reset(2);
    for (int i = 0; i < 3; i++) push_word({32'h4000 + 32'(4*i+3), 32'h4000 + 32'(4*i+2),
                                            32'h4000 + 32'(4*i+1), 32'h4000 + 32'(4*i)});
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      pix_ready = ~pix_ready;
      @(posedge clk); #1;
      k++;
    end
    if (exp_q.size() != 0) check_val("t4_drain_timeout", 32'(exp_q.size()), 32'd0);
    check_val("t4_xfers", 32'(xfer_cnt), 32'd12);
    check_val("t4_rd_ahead_le2", 32'(ahead_max <= 2), 32'd1);

    // Starvation mid-line raises a sticky underrun.
    pix_ready = 1'b0;
    do_reset(2);
    pix_ready = 1'b1;
    push_word(128'h5000_0004_5000_0003_5000_0002_5000_0001);
    wait_drain("t5", 50);
    check_val("t5_underrun_before", 32'(underrun), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    check_val("t5_underrun_set", 32'(underrun), 32'd1);
    pix_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check_val("t5_underrun_sticky", 32'(underrun), 32'd1);
    do_reset(2);
    check_val("t5_underrun_cleared", 32'(underrun), 32'd0);

    // Reset while a read is returning: that word is lost, next word starts at lane 0.
    pix_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word({32'h6000 + 32'(4*i+3), 32'h6000 + 32'(4*i+2),
                                            32'h6000 + 32'(4*i+1), 32'h6000 + 32'(4*i)});
    w4 = fifo_q[3];
    k = 0;
    while (xfer_cnt < 5 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check_val("t6_reached_word2", 32'(xfer_cnt >= 5), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("t6_rst_pix_valid", 32'(pix_valid), 32'd0);
    check_val("t6_rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
    rebuild_exp();
    clear_stats();
    rst = 1'b0;
    wait_drain("t6", 50);
    check_val("t6_first_pix", first_pix, w4[31:0]);
    check_val("t6_xfers", 32'(xfer_cnt), 32'd4);

    pix_ready = 1'b0;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
